// File: rtl/alu_sequencer.sv
// Command-side initiator for the 16-bit ALU: registers operands/opcode, captures the
// ALU outputs one cycle later, and returns them over a valid/ready response channel.
module alu_sequencer #(
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [3:0]           cmd_opcode,
    input  logic [15:0]          cmd_num_1,
    input  logic [15:0]          cmd_num_2,
    input  logic                 cmd_use_acc,
    output logic [15:0]          alu_num_1,
    output logic [15:0]          alu_num_2,
    output logic [3:0]           alu_opcode,
    input  logic [15:0]          alu_result,
    input  logic                 alu_zero,
    input  logic                 alu_carry,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [15:0]          rsp_result,
    output logic                 rsp_zero,
    output logic                 rsp_carry,
    output logic                 rsp_err,
    output logic [15:0]          acc,
    output logic [CNT_WIDTH-1:0] op_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t               state_reg,      state_next;
    logic                 cmd_ready_reg,  cmd_ready_next;
    logic [15:0]          alu_num_1_reg,  alu_num_1_next;
    logic [15:0]          alu_num_2_reg,  alu_num_2_next;
    logic [3:0]           alu_opcode_reg, alu_opcode_next;
    logic                 err_reg,        err_next;
    logic [15:0]          rsp_result_reg, rsp_result_next;
    logic                 rsp_zero_reg,   rsp_zero_next;
    logic                 rsp_carry_reg,  rsp_carry_next;
    logic                 rsp_err_reg,    rsp_err_next;
    logic [15:0]          acc_reg,        acc_next;
    logic [CNT_WIDTH-1:0] op_count_reg,   op_count_next;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= IDLE;
            cmd_ready_reg  <= 1'b0;
            alu_num_1_reg  <= '0;
            alu_num_2_reg  <= '0;
            alu_opcode_reg <= '0;
            err_reg        <= 1'b0;
            rsp_result_reg <= '0;
            rsp_zero_reg   <= 1'b0;
            rsp_carry_reg  <= 1'b0;
            rsp_err_reg    <= 1'b0;
            acc_reg        <= '0;
            op_count_reg   <= '0;
        end else begin
            state_reg      <= state_next;
            cmd_ready_reg  <= cmd_ready_next;
            alu_num_1_reg  <= alu_num_1_next;
            alu_num_2_reg  <= alu_num_2_next;
            alu_opcode_reg <= alu_opcode_next;
            err_reg        <= err_next;
            rsp_result_reg <= rsp_result_next;
            rsp_zero_reg   <= rsp_zero_next;
            rsp_carry_reg  <= rsp_carry_next;
            rsp_err_reg    <= rsp_err_next;
            acc_reg        <= acc_next;
            op_count_reg   <= op_count_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        alu_num_1_next  = alu_num_1_reg;
        alu_num_2_next  = alu_num_2_reg;
        alu_opcode_next = alu_opcode_reg;
        err_next        = err_reg;
        rsp_result_next = rsp_result_reg;
        rsp_zero_next   = rsp_zero_reg;
        rsp_carry_next  = rsp_carry_reg;
        rsp_err_next    = rsp_err_reg;
        acc_next        = acc_reg;
        op_count_next   = op_count_reg;

        case (state_reg)
            IDLE: begin
                // cmd_ready_reg is low until the first edge after reset release.
                if (cmd_valid && cmd_ready_reg) begin
                    alu_num_1_next  = cmd_use_acc ? acc_reg : cmd_num_1;
                    alu_num_2_next  = cmd_num_2;
                    alu_opcode_next = cmd_opcode;
                    err_next        = cmd_opcode[3];
                    state_next      = EXEC;
                end
            end
            EXEC: begin
                rsp_result_next = alu_result;
                rsp_zero_next   = alu_zero;
                // Carry only has meaning for add.
                rsp_carry_next  = alu_carry & (alu_opcode_reg == 4'b0000);
                rsp_err_next    = err_reg;
                state_next      = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    op_count_next = op_count_reg + CNT_WIDTH'(1);
                    if (!rsp_err_reg) begin
                        acc_next = rsp_result_reg;
                    end
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        cmd_ready_next = (state_next == IDLE);
    end

    assign cmd_ready  = cmd_ready_reg;
    assign alu_num_1  = alu_num_1_reg;
    assign alu_num_2  = alu_num_2_reg;
    assign alu_opcode = alu_opcode_reg;
    assign rsp_valid  = (state_reg == RESP);
    assign rsp_result = rsp_result_reg;
    assign rsp_zero   = rsp_zero_reg;
    assign rsp_carry  = rsp_carry_reg;
    assign rsp_err    = rsp_err_reg;
    assign acc        = acc_reg;
    assign op_count   = op_count_reg;

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer: a transaction-level model plus per-cycle compare,
// with a second instance (CNT_WIDTH=2) to exercise counter wrap.
module tb_alu_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic [3:0]  cmd_opcode = 4'h0;
    logic [15:0] cmd_num_1 = 16'h0;
    logic [15:0] cmd_num_2 = 16'h0;
    logic        cmd_use_acc = 1'b0;
    logic        rsp_ready = 1'b0;

    logic        cmd_ready, rsp_valid, rsp_zero, rsp_carry, rsp_err;
    logic [15:0] alu_num_1, alu_num_2, rsp_result, acc, op_count;
    logic [3:0]  alu_opcode;
    logic [15:0] alu_result;
    logic        alu_zero, alu_carry;

    logic        w_cmd_ready, w_rsp_valid, w_rsp_zero, w_rsp_carry, w_rsp_err;
    logic [15:0] w_alu_num_1, w_alu_num_2, w_rsp_result, w_acc;
    logic [1:0]  w_op_count;
    logic [3:0]  w_alu_opcode;
    logic [15:0] w_alu_result;
    logic        w_alu_zero, w_alu_carry;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    // Reference ALU: undefined opcodes give result 0 / zero 1; non-add ops drive carry
    // high where it is meaningless so that masking is visible.
    function automatic logic [17:0] alu_f(input logic [15:0] a, input logic [15:0] b,
                                          input logic [3:0] op);
        logic [16:0] s;
        logic [15:0] r;
        logic        c;
        s = '0;
        r = '0;
        c = 1'b1;
        case (op)
            4'h0: begin s = {1'b0, a} + {1'b0, b}; r = s[15:0]; c = s[16]; end
            4'h1: begin s = {1'b0, a} - {1'b0, b}; r = s[15:0]; c = s[16]; end
            4'h2: r = a & b;
            4'h3: r = a | b;
            4'h4: r = a ^ b;
            4'h5: r = ~a;
            4'h6: begin r = {a[14:0], 1'b0}; c = a[15]; end
            4'h7: begin r = {1'b0, a[15:1]}; c = a[0]; end
            default: begin r = '0; c = 1'b1; end
        endcase
        return {c, (r == 16'h0), r};
    endfunction

    assign {alu_carry, alu_zero, alu_result}       = alu_f(alu_num_1, alu_num_2, alu_opcode);
    assign {w_alu_carry, w_alu_zero, w_alu_result} = alu_f(w_alu_num_1, w_alu_num_2, w_alu_opcode);

    alu_sequencer #(.CNT_WIDTH(16)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_opcode(cmd_opcode),
        .cmd_num_1(cmd_num_1), .cmd_num_2(cmd_num_2), .cmd_use_acc(cmd_use_acc),
        .alu_num_1(alu_num_1), .alu_num_2(alu_num_2), .alu_opcode(alu_opcode),
        .alu_result(alu_result), .alu_zero(alu_zero), .alu_carry(alu_carry),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
        .rsp_zero(rsp_zero), .rsp_carry(rsp_carry), .rsp_err(rsp_err),
        .acc(acc), .op_count(op_count)
    );

    alu_sequencer #(.CNT_WIDTH(2)) dut_w (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(w_cmd_ready), .cmd_opcode(cmd_opcode),
        .cmd_num_1(cmd_num_1), .cmd_num_2(cmd_num_2), .cmd_use_acc(cmd_use_acc),
        .alu_num_1(w_alu_num_1), .alu_num_2(w_alu_num_2), .alu_opcode(w_alu_opcode),
        .alu_result(w_alu_result), .alu_zero(w_alu_zero), .alu_carry(w_alu_carry),
        .rsp_valid(w_rsp_valid), .rsp_ready(rsp_ready), .rsp_result(w_rsp_result),
        .rsp_zero(w_rsp_zero), .rsp_carry(w_rsp_carry), .rsp_err(w_rsp_err),
        .acc(w_acc), .op_count(w_op_count)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model state: transaction-level view of the sequencer (owned by the compare process).
    bit          m_armed = 1'b0;
    bit          m_inflight = 1'b0;
    int          m_since = 0;
    logic [15:0] m_acc = '0, m_cnt = '0, m_a = '0, m_b = '0, e_res = '0;
    logic [3:0]  m_op = '0;
    logic        e_z = 1'b0, e_c = 1'b0, e_e = 1'b0;

    initial begin
        logic [17:0] f;
        forever begin
            @(negedge clk);
            if (rst) begin
                chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
                chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
                chk("rst_acc", 32'(acc), 32'd0);
                chk("rst_op_count", 32'(op_count), 32'd0);
                chk("rst_alu_num_1", 32'(alu_num_1), 32'd0);
                chk("rst_rsp_result", 32'(rsp_result), 32'd0);
                m_armed = 1'b0; m_inflight = 1'b0; m_since = 0;
                m_acc = '0; m_cnt = '0; m_a = '0; m_b = '0; m_op = '0;
            end else begin
                chk("cmd_ready", 32'(cmd_ready), 32'(m_armed && !m_inflight));
                chk("rsp_valid", 32'(rsp_valid), 32'(m_inflight && m_since >= 2));
                chk("w_rsp_valid", 32'(w_rsp_valid), 32'(m_inflight && m_since >= 2));
                if (m_inflight && m_since >= 2) begin
                    chk("rsp_result", 32'(rsp_result), 32'(e_res));
                    chk("rsp_zero", 32'(rsp_zero), 32'(e_z));
                    chk("rsp_carry", 32'(rsp_carry), 32'(e_c));
                    chk("rsp_err", 32'(rsp_err), 32'(e_e));
                end
                chk("acc", 32'(acc), 32'(m_acc));
                chk("op_count", 32'(op_count), 32'(m_cnt));
                chk("w_op_count", 32'(w_op_count), 32'(m_cnt[1:0]));
                chk("alu_num_1", 32'(alu_num_1), 32'(m_a));
                chk("alu_num_2", 32'(alu_num_2), 32'(m_b));
                chk("alu_opcode", 32'(alu_opcode), 32'(m_op));
                // Effect of the coming rising edge.
                if (m_inflight) begin
                    if (m_since >= 2 && rsp_ready) begin
                        m_inflight = 1'b0;
                        m_cnt = m_cnt + 16'd1;
                        if (!e_e) m_acc = e_res;
                    end else begin
                        m_since++;
                    end
                end else if (m_armed && cmd_valid) begin
                    m_a = cmd_use_acc ? m_acc : cmd_num_1;
                    m_b = cmd_num_2;
                    m_op = cmd_opcode;
                    f = alu_f(m_a, m_b, m_op);
                    e_res = f[15:0];
                    e_z = f[16];
                    e_c = (m_op == 4'h0) ? f[17] : 1'b0;
                    e_e = m_op[3];
                    m_inflight = 1'b1;
                    m_since = 1;
                end
                m_armed = 1'b1;
            end
        end
    end

    // One command/response transaction; hold = extra cycles rsp_ready stays low in RESP.
    task automatic do_op(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                         input logic ua, input int hold,
                         output logic [15:0] r, output logic z, output logic c,
                         output logic e, output logic [15:0] an1, output int lat);
        int t;
        @(posedge clk); #1;
        cmd_valid = 1'b1; cmd_opcode = op; cmd_num_1 = a; cmd_num_2 = b; cmd_use_acc = ua;
        rsp_ready = (hold == 0);
        t = 0;
        do begin @(negedge clk); t++; end while (!cmd_ready && t < 20);
        chk("cmd_accept", 32'(cmd_ready), 32'd1);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        lat = 0;
        an1 = '0;
        do begin
            @(negedge clk);
            lat++;
            if (lat == 1) an1 = alu_num_1;
        end while (!rsp_valid && lat < 20);
        chk("rsp_latency", 32'(lat), 32'd2);
        if (hold > 0) begin
            for (int i = 0; i < hold; i++) begin
                @(posedge clk); #1;
                chk("bp_cmd_ready", 32'(cmd_ready), 32'd0);
                chk("bp_rsp_valid", 32'(rsp_valid), 32'd1);
            end
            rsp_ready = 1'b1;
            @(negedge clk);
        end
        r = rsp_result; z = rsp_zero; c = rsp_carry; e = rsp_err;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        $display("op=%h a=%h b=%h use_acc=%0d -> result=%h zero=%0d carry=%0d err=%0d acc=%h count=%0d",
                 op, a, b, ua, r, z, c, e, acc, op_count);
    endtask

    initial begin
        #150000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] r, an1;
        logic        z, c, e;
        int          lat;
        int          t;

        #1;
        chk("init_cmd_ready", 32'(cmd_ready), 32'd0);
        chk("init_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("init_op_count", 32'(op_count), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk("ready_before_edge", 32'(cmd_ready), 32'd0);
        @(posedge clk); #1;
        chk("ready_after_edge", 32'(cmd_ready), 32'd1);

        // Add with carry-out.
        do_op(4'h0, 16'hFFFF, 16'h0001, 1'b0, 0, r, z, c, e, an1, lat);
        chk("add_res", 32'(r), 32'h0000);
        chk("add_zero", 32'(z), 32'd1);
        chk("add_carry", 32'(c), 32'd1);
        chk("add_err", 32'(e), 32'd0);
        chk("add_acc", 32'(acc), 32'h0000);
        chk("add_cnt", 32'(op_count), 32'd1);

        // Chain through the accumulator.
        do_op(4'h0, 16'h0003, 16'h0004, 1'b0, 0, r, z, c, e, an1, lat);
        chk("chain1_res", 32'(r), 32'h0007);
        do_op(4'h1, 16'hDEAD, 16'h0002, 1'b1, 0, r, z, c, e, an1, lat);
        chk("chain2_num1", 32'(an1), 32'h0007);
        chk("chain2_res", 32'(r), 32'h0005);
        chk("chain2_carry", 32'(c), 32'd0);
        chk("chain2_acc", 32'(acc), 32'h0005);

        // Backpressure on an OR.
        do_op(4'h3, 16'h00F0, 16'h0F00, 1'b0, 4, r, z, c, e, an1, lat);
        chk("or_res", 32'(r), 32'h0FF0);
        chk("or_carry", 32'(c), 32'd0);
        chk("or_cnt", 32'(op_count), 32'd4);
        chk("or_acc", 32'(acc), 32'h0FF0);

        // Undefined opcode leaves acc alone.
        do_op(4'hA, 16'h1234, 16'h5678, 1'b0, 0, r, z, c, e, an1, lat);
        chk("undef_err", 32'(e), 32'd1);
        chk("undef_res", 32'(r), 32'h0000);
        chk("undef_zero", 32'(z), 32'd1);
        chk("undef_carry", 32'(c), 32'd0);
        chk("undef_acc", 32'(acc), 32'h0FF0);
        chk("undef_cnt", 32'(op_count), 32'd5);

        // Shift-left: ALU carry is set but must be masked.
        do_op(4'h6, 16'h8000, 16'h0000, 1'b0, 0, r, z, c, e, an1, lat);
        chk("shl_res", 32'(r), 32'h0000);
        chk("shl_zero", 32'(z), 32'd1);
        chk("shl_carry", 32'(c), 32'd0);

        do_op(4'h0, 16'h1111, 16'h2222, 1'b0, 0, r, z, c, e, an1, lat);
        chk("pre_rst_acc", 32'(acc), 32'h3333);

        // Asynchronous reset while a command is in EXEC.
        @(posedge clk); #1;
        cmd_valid = 1'b1; cmd_opcode = 4'h0; cmd_num_1 = 16'h00AA; cmd_num_2 = 16'h0001;
        cmd_use_acc = 1'b0; rsp_ready = 1'b1;
        t = 0;
        do begin @(negedge clk); t++; end while (!cmd_ready && t < 20);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        chk("exec_num1", 32'(alu_num_1), 32'h00AA);
        #2 rst = 1'b1;
        #1;
        chk("amid_cmd_ready", 32'(cmd_ready), 32'd0);
        chk("amid_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("amid_acc", 32'(acc), 32'd0);
        chk("amid_op_count", 32'(op_count), 32'd0);
        chk("amid_w_op_count", 32'(w_op_count), 32'd0);
        chk("amid_alu_num_1", 32'(alu_num_1), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1 chk("post_rst_no_rsp", 32'(rsp_valid), 32'd0);

        do_op(4'h0, 16'h0001, 16'h0001, 1'b0, 0, r, z, c, e, an1, lat);
        chk("fresh_res", 32'(r), 32'h0002);
        chk("fresh_cnt", 32'(op_count), 32'd1);
        chk("wrap_1", 32'(w_op_count), 32'd1);

        do_op(4'h4, 16'h00FF, 16'h0F0F, 1'b0, 0, r, z, c, e, an1, lat);
        chk("xor_res", 32'(r), 32'h0FF0);
        chk("wrap_2", 32'(w_op_count), 32'd2);
        do_op(4'h2, 16'hF0F0, 16'hFF00, 1'b0, 0, r, z, c, e, an1, lat);
        chk("and_res", 32'(r), 32'hF000);
        chk("wrap_3", 32'(w_op_count), 32'd3);
        do_op(4'h7, 16'h0003, 16'h0000, 1'b0, 0, r, z, c, e, an1, lat);
        chk("shr_res", 32'(r), 32'h0001);
        chk("shr_carry", 32'(c), 32'd0);
        chk("wrap_0", 32'(w_op_count), 32'd0);
        chk("nowrap_cnt", 32'(op_count), 32'd4);

        repeat (2) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
